// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator and pixel output stage (optional colour bars: VGA_TESTPATTERN_EN)
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int MEM_LAT  = 1,
    parameter int ADDR_W   = 19
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic [11:0]       colour,
`ifdef VGA_TESTPATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic [ADDR_W-1:0] addrb,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        vgared,
    output logic [3:0]        vgagreen,
    output logic [3:0]        vgablue,
    output logic              de,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic           HS_ON    = 1'(HS_POL);
    localparam logic           VS_ON    = 1'(VS_POL);

    // Pipeline word: [0]=active [1]=hsync [2]=vsync [3]=frame origin (+ bar index when patterns enabled)
`ifdef VGA_TESTPATTERN_EN
    localparam int PW    = 7;
    localparam int BAR_W = H_ACTIVE / 8;
`else
    localparam int PW    = 4;
`endif

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic           w_h_wrap;
    logic           w_v_wrap;
    logic           w_active;
    logic           w_hs_raw;
    logic           w_vs_raw;
    logic           w_origin;
    logic [PW-1:0]  w_s0;
    logic [PW-1:0]  w_del;
    logic [11:0]    w_pix;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_raw = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    assign w_vs_raw = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Raster counters: h wraps every line, v advances only on the h wrap
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + V_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + H_W'(1);
        end
    end

    // Linear read address tracks the counters without a multiplier; holds through blanking
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            addrb <= '0;
        end else if (w_h_wrap && w_v_wrap) begin
            addrb <= '0;
        end else if (w_active) begin
            addrb <= addrb + ADDR_W'(1);
        end
    end

`ifdef VGA_TESTPATTERN_EN
    logic [2:0] w_bar;
    logic [2:0] w_bar_d;

    // Bar index from the horizontal position; bars are H_ACTIVE/8 pixels wide
    always_comb begin
        w_bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (r_h_cnt >= H_W'(i * BAR_W)) w_bar = 3'(i);
        end
    end

    assign w_s0    = {w_bar, w_origin, w_vs_raw, w_hs_raw, w_active};
    assign w_bar_d = w_del[6:4];
    // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0]
    assign w_pix   = pattern_sel ? {{4{~w_bar_d[1]}}, {4{~w_bar_d[2]}}, {4{~w_bar_d[0]}}} : colour;
`else
    assign w_s0    = {w_origin, w_vs_raw, w_hs_raw, w_active};
    assign w_pix   = colour;
`endif

    generate
        if (MEM_LAT == 0) begin : g_nolat
            assign w_del = w_s0;
        end else begin : g_lat
            logic [PW-1:0] r_sh [MEM_LAT];

            // Delay timing flags by the framebuffer read latency so they meet the returned colour
            always_ff @(posedge clk_vga or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MEM_LAT; i++) r_sh[i] <= '0;
                end else begin
                    r_sh[0] <= w_s0;
                    for (int i = 1; i < MEM_LAT; i++) r_sh[i] <= r_sh[i-1];
                end
            end

            assign w_del = r_sh[MEM_LAT-1];
        end
    endgenerate

    // Output register: blanking forces black, syncs take their configured polarity
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            {vgared, vgagreen, vgablue} <= 12'h000;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
        end else begin
            {vgared, vgagreen, vgablue} <= w_del[0] ? w_pix : 12'h000;
            de          <= w_del[0];
            frame_start <= w_del[3];
            hsync       <= w_del[1] ? HS_ON : ~HS_ON;
            vsync       <= w_del[2] ? VS_ON : ~VS_ON;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic white;
    int   checks = 0;
    int   errors = 0;
    int   k;
    int   wsw;

    always #5 clk = ~clk;

    // Small-raster DUTs: MEM_LAT 0, 1, 3
    logic [4:0]  a0, a1, a3;
    logic        hs0, vs0, de0, fs0, hs1, vs1, de1, fs1, hs3, vs3, de3, fs3;
    logic [3:0]  r0, g0, b0, r1, g1, b1, r3, g3, b3;
    logic [11:0] col0, col1, col3, c1;
    logic [11:0] c3 [3];

    // Default-raster DUT
    logic [18:0] ad;
    logic        hsd, vsd, ded, fsd;
    logic [3:0]  rd, gd, bd;
    logic [11:0] cold, cd;

    assign col0 = white ? 12'hFFF : {7'd0, a0};
    assign col1 = white ? 12'hFFF : c1;
    assign col3 = white ? 12'hFFF : c3[2];
    assign cold = white ? 12'hFFF : cd;

    always @(posedge clk) begin
        c1    <= {7'd0, a1};
        c3[0] <= {7'd0, a3};
        c3[1] <= c3[0];
        c3[2] <= c3[1];
        cd    <= ad[11:0];
    end

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .MEM_LAT(0), .ADDR_W(5)) u0 (
        .clk_vga(clk), .rst(rst), .colour(col0),
`ifdef VGA_TESTPATTERN_EN
        .pattern_sel(1'b0),
`endif
        .addrb(a0), .hsync(hs0), .vsync(vs0), .vgared(r0), .vgagreen(g0), .vgablue(b0),
        .de(de0), .frame_start(fs0));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .MEM_LAT(1), .ADDR_W(5)) u1 (
        .clk_vga(clk), .rst(rst), .colour(col1),
`ifdef VGA_TESTPATTERN_EN
        .pattern_sel(1'b0),
`endif
        .addrb(a1), .hsync(hs1), .vsync(vs1), .vgared(r1), .vgagreen(g1), .vgablue(b1),
        .de(de1), .frame_start(fs1));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .MEM_LAT(3), .ADDR_W(5)) u3 (
        .clk_vga(clk), .rst(rst), .colour(col3),
`ifdef VGA_TESTPATTERN_EN
        .pattern_sel(1'b0),
`endif
        .addrb(a3), .hsync(hs3), .vsync(vs3), .vgared(r3), .vgagreen(g3), .vgablue(b3),
        .de(de3), .frame_start(fs3));

    vga_timing_gen ud (
        .clk_vga(clk), .rst(rst), .colour(cold),
`ifdef VGA_TESTPATTERN_EN
        .pattern_sel(1'b0),
`endif
        .addrb(ad), .hsync(hsd), .vsync(vsd), .vgared(rd), .vgagreen(gd), .vgablue(bd),
        .de(ded), .frame_start(fsd));

`ifdef VGA_TESTPATTERN_EN
    logic [18:0] atp;
    logic        hstp, vstp, detp, fstp;
    logic [3:0]  rtp, gtp, btp;

    vga_timing_gen utp (
        .clk_vga(clk), .rst(rst), .colour(12'hFFF), .pattern_sel(1'b1),
        .addrb(atp), .hsync(hstp), .vsync(vstp), .vgared(rtp), .vgagreen(gtp), .vgablue(btp),
        .de(detp), .frame_start(fstp));
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected values from the raster definition: k = clock edges since reset release
    task automatic chk(input string tag, input int lat, input int ha, input int hfp, input int hsw,
                       input int hbp, input int va, input int vfp, input int vsw, input int vbp,
                       input int aw, input int mode, input logic [31:0] o_a, input logic o_de,
                       input logic o_hs, input logic o_vs, input logic o_fs, input logic [11:0] o_rgb);
        int ht, vt, f, h, v, s, ea;
        logic e_de, e_hs, e_vs, e_fs;
        logic [11:0] e_rgb;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        f  = k % (ht * vt);
        h  = f % ht;
        v  = f / ht;
        if (v < va) ea = (h < ha) ? v * ha + h : v * ha + ha;
        else        ea = ha * va;
        ea = ea % (1 << aw);
        check($sformatf("%s k=%0d addrb", tag, k), o_a, ea);
        s = k - lat - 1;
        if (s < 0) begin
            e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = 12'h000;
        end else begin
            f     = s % (ht * vt);
            h     = f % ht;
            v     = f / ht;
            e_de  = (h < ha) && (v < va);
            e_hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
            e_vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
            e_fs  = (f == 0);
            e_rgb = 12'h000;
            if (e_de) begin
                if (mode == 1) begin
                    case (h / (ha / 8))
                        0: e_rgb = 12'hFFF;
                        1: e_rgb = 12'hFF0;
                        2: e_rgb = 12'h0FF;
                        3: e_rgb = 12'h0F0;
                        4: e_rgb = 12'hF0F;
                        5: e_rgb = 12'hF00;
                        6: e_rgb = 12'h00F;
                        default: e_rgb = 12'h000;
                    endcase
                end else if (s >= wsw - lat) begin
                    e_rgb = 12'hFFF;
                end else begin
                    e_rgb = 12'(v * ha + h);
                end
            end
        end
        check($sformatf("%s k=%0d de", tag, k), o_de, e_de);
        check($sformatf("%s k=%0d hsync", tag, k), o_hs, e_hs);
        check($sformatf("%s k=%0d vsync", tag, k), o_vs, e_vs);
        check($sformatf("%s k=%0d frame_start", tag, k), o_fs, e_fs);
        check($sformatf("%s k=%0d rgb", tag, k), o_rgb, e_rgb);
    endtask

    task automatic chk_all();
        chk("lat0", 0, 8, 2, 2, 2, 4, 1, 1, 1, 5, 0, a0, de0, hs0, vs0, fs0, {r0, g0, b0});
        chk("lat1", 1, 8, 2, 2, 2, 4, 1, 1, 1, 5, 0, a1, de1, hs1, vs1, fs1, {r1, g1, b1});
        chk("lat3", 3, 8, 2, 2, 2, 4, 1, 1, 1, 5, 0, a3, de3, hs3, vs3, fs3, {r3, g3, b3});
        chk("dflt", 1, 640, 16, 96, 48, 480, 10, 2, 33, 19, 0, ad, ded, hsd, vsd, fsd, {rd, gd, bd});
`ifdef VGA_TESTPATTERN_EN
        chk("tpat", 1, 640, 16, 96, 48, 480, 10, 2, 33, 19, 1, atp, detp, hstp, vstp, fstp, {rtp, gtp, btp});
`endif
    endtask

    initial begin
        rst   = 1'b1;
        white = 1'b0;
        wsw   = 256;
        k     = 0;
        repeat (3) @(negedge clk);
        chk_all();
        rst = 1'b0;

        // Four-plus small frames; colour forced white from a blanking point onward
        repeat (425) begin
            @(negedge clk);
            k++;
            chk_all();
            if (k == 2) check("lat1 first de", de1, 1'b1);
            if (k == 256) white = 1'b1;
        end

        // k=425 leaves the lat1 counters at (5,2); assert reset mid-line
        #1 rst = 1'b1;
        #1;
        check("async rst rgb", {r1, g1, b1}, 12'h000);
        check("async rst de", de1, 1'b0);
        check("async rst hsync", hs1, 1'b1);
        check("async rst vsync", vs1, 1'b1);
        check("async rst addrb", a1, 5'd0);
        check("async rst dflt de", ded, 1'b0);
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        white = 1'b0;
        wsw   = 1 << 30;
        k     = 0;
        chk_all();

        // Restart from (0,0); run past two default-size lines
        repeat (1700) begin
            @(negedge clk);
            k++;
            chk_all();
            if (k == 800) check("dflt line1 addrb", ad, 19'd640);
            if (k == 657) check("dflt hsync before", hsd, 1'b1);
            if (k == 658) check("dflt hsync start", hsd, 1'b0);
            if (k == 753) check("dflt hsync last", hsd, 1'b0);
            if (k == 754) check("dflt hsync end", hsd, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
